// File: rtl/dna_pkg.sv
// Shared nucleotide encoding, ASCII constants and load-control state for the DNA search datapath.
// Pure declarations: no latency, no flow control.
package dna_pkg;

  localparam int CODE_W = 4;

  localparam logic [CODE_W-1:0] NT_A   = 4'b0001;
  localparam logic [CODE_W-1:0] NT_C   = 4'b0010;
  localparam logic [CODE_W-1:0] NT_G   = 4'b0100;
  localparam logic [CODE_W-1:0] NT_T   = 4'b1000;
  localparam logic [CODE_W-1:0] NT_INV = 4'b0000;

  localparam logic [7:0] ASCII_A_UC = 8'h41;
  localparam logic [7:0] ASCII_C_UC = 8'h43;
  localparam logic [7:0] ASCII_G_UC = 8'h47;
  localparam logic [7:0] ASCII_T_UC = 8'h54;
  localparam logic [7:0] ASCII_A_LC = 8'h61;
  localparam logic [7:0] ASCII_C_LC = 8'h63;
  localparam logic [7:0] ASCII_G_LC = 8'h67;
  localparam logic [7:0] ASCII_T_LC = 8'h74;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_KEY  = 2'd1,
    LOAD_DATA = 2'd2,
    DONE      = 2'd3
  } load_state_t;

  typedef struct packed {
    logic              valid;
    logic [CODE_W-1:0] code;
  } nt_code_t;

endpackage

// File: rtl/nt_encoder.sv
// Case-insensitive ASCII nucleotide -> {valid, one-hot code}; unknown bytes give code 0, valid 0.
// Combinational, zero latency, no flow control.
module nt_encoder
  import dna_pkg::*;
(
  input  logic [7:0] char_in,
  output nt_code_t   nt
);

  always_comb begin
    nt = '{valid: 1'b0, code: NT_INV};
    case (char_in)
      ASCII_A_UC, ASCII_A_LC: nt = '{valid: 1'b1, code: NT_A};
      ASCII_C_UC, ASCII_C_LC: nt = '{valid: 1'b1, code: NT_C};
      ASCII_G_UC, ASCII_G_LC: nt = '{valid: 1'b1, code: NT_G};
      ASCII_T_UC, ASCII_T_LC: nt = '{valid: 1'b1, code: NT_T};
      default:                nt = '{valid: 1'b0, code: NT_INV};
    endcase
  end

endmodule

// File: rtl/dna_sequence_loader.sv
// Packs an ASCII nucleotide stream into key then data registers (first char in MSB nibble).
// One byte per transfer; loaded the cycle after the last data byte; in_ready low outside loading.
module dna_sequence_loader #(
  parameter int DATA_NT = 256,
  parameter int KEY_NT  = 16,
  parameter int CODE_W  = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      in_valid,
  input  logic [7:0]                in_byte,
  output logic                      in_ready,
  input  logic                      release_pulse,
  output logic [KEY_NT*CODE_W-1:0]  key,
  output logic [DATA_NT*CODE_W-1:0] data,
  output logic                      loaded,
  output logic                      bad_char
);

  import dna_pkg::*;

  localparam int KEY_W  = KEY_NT * CODE_W;
  localparam int DATA_W = DATA_NT * CODE_W;
  localparam int CNT_W  = $clog2(DATA_NT);

  localparam logic [CNT_W-1:0] KEY_LAST  = CNT_W'(KEY_NT - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_NT - 1);

  load_state_t      state, state_nxt;
  logic [CNT_W-1:0] nt_count;
  nt_code_t         enc;
  logic             clear_all;
  logic             take_key;
  logic             take_data;
  logic             last_nt;

  nt_encoder u_nt_encoder (
    .char_in (in_byte),
    .nt      (enc)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A start while loading wins over any byte offered in the same cycle.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    loaded    = 1'b0;
    clear_all = 1'b0;
    take_key  = 1'b0;
    take_data = 1'b0;
    last_nt   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          clear_all = 1'b1;
          state_nxt = LOAD_KEY;
        end
      end
      LOAD_KEY: begin
        in_ready = 1'b1;
        if (start) begin
          clear_all = 1'b1;
        end else if (in_valid) begin
          take_key = 1'b1;
          last_nt  = (nt_count == KEY_LAST);
          if (last_nt) state_nxt = LOAD_DATA;
        end
      end
      LOAD_DATA: begin
        in_ready = 1'b1;
        if (start) begin
          clear_all = 1'b1;
          state_nxt = LOAD_KEY;
        end else if (in_valid) begin
          take_data = 1'b1;
          last_nt   = (nt_count == DATA_LAST);
          if (last_nt) state_nxt = DONE;
        end
      end
      DONE: begin
        loaded = 1'b1;
        if (release_pulse) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset || clear_all) begin
      nt_count <= '0;
      key      <= '0;
      data     <= '0;
      bad_char <= 1'b0;
    end else if (take_key || take_data) begin
      nt_count <= last_nt ? '0 : nt_count + CNT_W'(1);
      if (!enc.valid) bad_char <= 1'b1;
      for (int i = 0; i < KEY_NT; i++) begin
        if (take_key && nt_count == CNT_W'(i)) key[KEY_W-1-CODE_W*i -: CODE_W] <= enc.code;
      end
      for (int j = 0; j < DATA_NT; j++) begin
        if (take_data && nt_count == CNT_W'(j)) data[DATA_W-1-CODE_W*j -: CODE_W] <= enc.code;
      end
    end
  end

endmodule
